// File: rtl/pkt_skid_fifo.sv
// Packet-aware skid FIFO for a valid-only (no backpressure) packet stream.
// Overflow drops whole packets or truncates the open one with an error-marked eop.
module pkt_skid_fifo #(
    parameter int DEPTH       = 32,
    parameter int AF_THRESH   = 24,
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    input  logic                   in_valid,
    output logic                   out_almost_full,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            drop_cnt,
    output logic                   overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = DATA_WIDTH + EMPTY_WIDTH + 3;
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] AF_LEVEL  = CW'(AF_THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_next_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [WW-1:0]   mem_r [DEPTH];
    logic            room_s;
    logic            wr_s;
    logic            rd_s;
    logic            drop_s;
    logic [WW-1:0]   wr_word_s;
    logic            out_valid_r;
    logic            almost_full_r;
    logic [31:0]     drop_cnt_r;
    logic            overflow_err_r;

    // Admission check against start-of-cycle occupancy; the last slot is kept for eop/truncation.
    always_comb begin
        room_s = 1'b0;
        if (count_r < LAST_SLOT) begin
            room_s = 1'b1;
        end else if ((count_r == LAST_SLOT) && in_eop) begin
            room_s = 1'b1;
        end else begin
            room_s = 1'b0;
        end
    end

    // Framing state machine: decides write, drop and truncation for the incoming word.
    always_comb begin
        state_s   = state_r;
        wr_s      = 1'b0;
        drop_s    = 1'b0;
        wr_word_s = {in_sop, in_eop, in_empty, 1'b0, in_data};
        if (in_valid) begin
            if (in_sop) begin
                // A stray sop inside PKT or DROP simply starts a new packet.
                if (room_s) begin
                    wr_s    = 1'b1;
                    state_s = in_eop ? IDLE : PKT;
                end else begin
                    drop_s  = 1'b1;
                    state_s = in_eop ? IDLE : DROP;
                end
            end else begin
                case (state_r)
                    PKT: begin
                        if (room_s) begin
                            wr_s    = 1'b1;
                            state_s = in_eop ? IDLE : PKT;
                        end else if (count_r == LAST_SLOT) begin
                            wr_s      = 1'b1;
                            wr_word_s = {1'b0, 1'b1, {EMPTY_WIDTH{1'b0}}, 1'b1, in_data};
                            drop_s    = 1'b1;
                            state_s   = DROP;
                        end else begin
                            drop_s  = 1'b1;
                            state_s = DROP;
                        end
                    end
                    DROP: begin
                        state_s = in_eop ? IDLE : DROP;
                    end
                    IDLE: begin
                        state_s = IDLE;
                    end
                    default: begin
                        state_s = IDLE;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // Occupancy bookkeeping: reads never free space for a same-cycle write.
    always_comb begin
        rd_s         = out_valid_r & out_ready;
        count_next_s = count_r + CW'(wr_s) - CW'(rd_s);
    end

    // Control registers, pointers, flags and drop statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            count_r        <= '0;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            out_valid_r    <= 1'b0;
            almost_full_r  <= 1'b0;
            drop_cnt_r     <= 32'd0;
            overflow_err_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            count_r       <= count_next_s;
            out_valid_r   <= (count_next_s != '0);
            almost_full_r <= (count_next_s >= AF_LEVEL);
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (drop_s) begin
                drop_cnt_r     <= drop_cnt_r + 32'd1;
                overflow_err_r <= 1'b1;
            end
        end
    end

    // Word storage; contents are don't-care after reset so no reset is applied.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= wr_word_s;
        end
    end

    assign {out_sop, out_eop, out_empty, out_err, out_data} = mem_r[rd_ptr_r];
    assign out_valid       = out_valid_r;
    assign out_almost_full = almost_full_r;
    assign drop_cnt        = drop_cnt_r;
    assign overflow_err    = overflow_err_r;

endmodule
